nwc_result_reader: RTL and testbench

- Drains the NWC result memory after the convolution core has written it, and streams the 4096 coefficients out in natural order (0..4095) on a valid/ready interface.
- Memory layout is the NWC dual-bank layout:
  - "up" bank word k holds coefficient k.
  - "down" bank word k holds coefficient k+2048.
  - Addresses are byte addresses with a word stride of 4.
- Sits between the result BRAM read port and the host/DMA egress. It is the reader counterpart of the core's write side (addrw/out_wen).

---
 rtl/nwc_pkg.sv | 22 ++
 rtl/nwc_skid_fifo.sv | 49 ++++
 rtl/nwc_result_reader.sv | 100 ++++++++++
 tb/tb_nwc_result_reader.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nwc_pkg.sv
// Shared constants and FSM encoding for the NWC result reader.
// Describes the dual-bank layout: up bank holds 0..N_HALF-1, down bank holds the rest.
package nwc_pkg;

  localparam int N_HALF      = 2048;
  localparam int N_TOTAL     = 2 * N_HALF;
  localparam int ADDR_W      = 13;
  localparam int DATA_W      = 32;
  localparam int BEAT_W      = 12;
  localparam int WORD_STRIDE = 4;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'((N_HALF - 1) * WORD_STRIDE);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_TOTAL - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SWEEP_UP   = 2'd1,
    SWEEP_DOWN = 2'd2,
    DRAIN      = 2'd3
  } state_t;

endpackage

// File: rtl/nwc_skid_fifo.sv
// 2-entry FIFO of {last, data}; output valid the cycle after a push.
// Simultaneous push/pop keeps the count; the caller must never push into a full FIFO.
module nwc_skid_fifo
  import nwc_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [DATA_W:0] push_dat,
  input  logic            pop,
  output logic            out_vld,
  output logic [DATA_W:0] out_dat,
  output logic [1:0]      count
);

  logic [DATA_W:0] mem [2];
  logic            wr_ptr;
  logic            rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign out_vld = (count != 2'd0);
  assign out_dat = mem[rd_ptr];

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && count == 2'd2));

endmodule

// File: rtl/nwc_result_reader.sv
// Streams the 4096 NWC result coefficients in order; first beat valid 2 cycles after start.
// Reads are throttled so FIFO plus in-flight never exceeds 2, giving full rate at m_ready=1.
module nwc_result_reader
  import nwc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] addrr,
  input  logic [DATA_W-1:0] data_in_up,
  input  logic [DATA_W-1:0] data_in_down,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  state_t            state;
  logic              inflight;
  logic              tag_down;
  logic [BEAT_W-1:0] push_cnt;
  logic [1:0]        fifo_cnt;
  logic [1:0]        pending;
  logic              pop;
  logic              issue;
  logic              push_last;
  logic [DATA_W-1:0] push_dat;
  logic [DATA_W:0]   head_dat;

  assign pop = m_valid & m_ready;

  // Occupancy after this cycle's pop lets a slot freed by the consumer be refilled at once.
  assign pending   = fifo_cnt - {1'b0, pop} + {1'b0, inflight};
  assign issue     = ((state == SWEEP_UP) || (state == SWEEP_DOWN)) && (pending < 2'd2);
  assign push_dat  = tag_down ? data_in_down : data_in_up;
  assign push_last = (push_cnt == LAST_BEAT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      addrr    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      inflight <= 1'b0;
      tag_down <= 1'b0;
      push_cnt <= '0;
    end else begin
      done     <= 1'b0;
      inflight <= issue;
      if (issue) begin
        tag_down <= (state == SWEEP_DOWN);
        addrr    <= addrr + ADDR_W'(WORD_STRIDE);
      end
      if (inflight) begin
        push_cnt <= push_cnt + BEAT_W'(1);
      end
      case (state)
        IDLE: begin
          if (start) begin
            state    <= SWEEP_UP;
            busy     <= 1'b1;
            addrr    <= '0;
            push_cnt <= '0;
          end
        end
        SWEEP_UP: begin
          if (issue && addrr == LAST_ADDR) state <= SWEEP_DOWN;
        end
        SWEEP_DOWN: begin
          if (issue && addrr == LAST_ADDR) state <= DRAIN;
        end
        DRAIN: begin
          if (pop && m_last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  nwc_skid_fifo u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight),
    .push_dat ({push_last, push_dat}),
    .pop      (pop),
    .out_vld  (m_valid),
    .out_dat  (head_dat),
    .count    (fifo_cnt)
  );

  assign m_data = head_dat[DATA_W-1:0];
  assign m_last = m_valid & head_dat[DATA_W];

endmodule

// File: tb/tb_nwc_result_reader.sv
// Bench for nwc_result_reader: registered BRAM model, randomized/stalled m_ready,
// and an index-based reference of the expected 0..4095 stream.
module tb_nwc_result_reader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [12:0] addrr;
  logic [31:0] data_in_up;
  logic [31:0] data_in_down;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  int exp_idx  = 0;
  int issued   = 0;
  int done_cnt = 0;

  bit strict  = 0;
  bit stall_en = 0;
  bit rand_en = 0;

  nwc_result_reader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .addrr        (addrr),
    .data_in_up   (data_in_up),
    .data_in_down (data_in_down),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_last       (m_last),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (beat %0d, t=%0t)", tag, got, exp, exp_idx, $time);
    end
  endtask

  // Result BRAM: one-cycle registered read of the dual-bank layout.
  initial begin
    data_in_up   = '0;
    data_in_down = '0;
    forever begin
      @(posedge clk);
      data_in_up   <= 32'(addrr >> 2);
      data_in_down <= 32'(addrr >> 2) + 32'd2048;
    end
  end

  // Consumer ready: 10-cycle stalls at beats 100 and 2047, or random 50%.
  initial begin
    int stall_left = 0;
    bit st100 = 0;
    bit st2047 = 0;
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!stall_en) begin
        st100  = 0;
        st2047 = 0;
      end else if (exp_idx == 100 && !st100) begin
        st100 = 1;
        stall_left = 10;
      end else if (exp_idx == 2047 && !st2047) begin
        st2047 = 1;
        stall_left = 10;
      end
      if (stall_left > 0) begin
        m_ready = 1'b0;
        stall_left--;
      end else if (rand_en) begin
        m_ready = 1'($urandom_range(0, 1));
      end else begin
        m_ready = 1'b1;
      end
    end
  end

  // Stream monitor and reference: beat k must carry value k, last only on 4095.
  initial begin
    logic [12:0] prev_addr = '0;
    bit          prev_stall = 0;
    logic [31:0] prev_dat = '0;
    bit          expect_done = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_idx     = 0;
        issued      = 0;
        prev_addr   = '0;
        prev_stall  = 0;
        expect_done = 0;
      end else begin
        if (expect_done) begin
          chk("done_pulse", done, 1);
          chk("busy_drop", busy, 0);
          expect_done = 0;
        end
        if (done) done_cnt++;
        if (busy && addrr != prev_addr) issued++;
        prev_addr = addrr;
        if (busy) chk("addr_ahead", (issued - exp_idx) <= 2, 1);
        if (prev_stall) begin
          chk("hold_valid", m_valid, 1);
          chk("hold_data", m_data, prev_dat);
        end
        if (strict && busy && exp_idx > 0 && exp_idx < 4096) chk("no_gap", m_valid, 1);
        if (m_valid && m_ready) begin
          chk("beat_data", m_data, exp_idx);
          chk("beat_last", m_last, exp_idx == 4095);
          if (m_last) expect_done = 1;
          exp_idx++;
        end
        prev_stall = m_valid && !m_ready;
        prev_dat   = m_data;
        if (start && (!busy || done)) begin
          exp_idx = 0;
          issued  = 0;
        end
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_beats(input int target, input int budget);
    for (int i = 0; i < budget && exp_idx < target; i++) begin
      @(posedge clk);
      #1;
    end
    chk("beat_timeout", exp_idx >= target, 1);
  endtask

  task automatic finish_drain(input int base, input int n_done);
    for (int i = 0; i < 20000 && done_cnt < base + n_done; i++) begin
      @(posedge clk);
      #1;
    end
    chk("done_timeout", done_cnt >= base + n_done, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("done_total", done_cnt, base + n_done);
    chk("beat_total", exp_idx, 4096);
    chk("idle_busy", busy, 0);
    chk("idle_valid", m_valid, 0);
  endtask

  initial begin
    int base;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addrr", addrr, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_data", m_data, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Full-rate drain with latency checks.
    strict = 1;
    base = done_cnt;
    pulse_start();
    chk("lat_busy", busy, 1);
    chk("lat_addr0", addrr, 0);
    chk("lat_valid_e0", m_valid, 0);
    @(posedge clk);
    #1;
    chk("lat_valid_e1", m_valid, 0);
    chk("lat_addr1", addrr, 4);
    @(posedge clk);
    #1;
    chk("lat_valid_e2", m_valid, 1);
    chk("lat_data_e2", m_data, 0);
    finish_drain(base, 1);

    // Stalls at beat 100 and across the bank switch.
    strict = 0;
    stall_en = 1;
    base = done_cnt;
    pulse_start();
    finish_drain(base, 1);
    stall_en = 0;

    // Random 50% backpressure.
    rand_en = 1;
    base = done_cnt;
    pulse_start();
    finish_drain(base, 1);
    rand_en = 0;

    // Start while busy is ignored.
    strict = 1;
    base = done_cnt;
    pulse_start();
    wait_beats(500, 2000);
    pulse_start();
    chk("busy_start_busy", busy, 1);
    finish_drain(base, 1);

    // Asynchronous reset mid-drain, then a fresh drain.
    base = done_cnt;
    pulse_start();
    wait_beats(1500, 4000);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_addrr", addrr, 0);
    chk("arst_valid", m_valid, 0);
    chk("arst_last", m_last, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_data", m_data, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_valid", m_valid, 0);
    chk("post_rst_done", done_cnt, base);
    pulse_start();
    finish_drain(base, 1);

    // Start in the done cycle: back-to-back drains.
    base = done_cnt;
    pulse_start();
    for (int i = 0; i < 20000 && !done; i++) begin
      @(posedge clk);
      #1;
    end
    chk("b2b_done_seen", done, 1);
    pulse_start();
    chk("b2b_busy", busy, 1);
    finish_drain(base, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
